// File: rtl/ppm_pkg.sv
// rtl/ppm_pkg.sv - shared constants and helpers for pulse_period_meter
//
// Contents:
//   ppm_state_e / ST_*  measurement state encoding (IDLE=0, ARM=1, MEASURE=2)
//   STS_*               bit positions inside the STATUS byte
//   CTRL_*              bit positions inside the CTRL byte
//   sat_inc8            8-bit increment that sticks at 255
package ppm_pkg;

    typedef enum logic [1:0] {
        PPM_IDLE    = 2'd0,
        PPM_ARM     = 2'd1,
        PPM_MEASURE = 2'd2
    } ppm_state_e;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;

    localparam int STS_NEW      = 0;
    localparam int STS_OVF      = 1;
    localparam int STS_STATE_LO = 2;
    localparam int STS_STATE_HI = 3;
    localparam int STS_LVL      = 7;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_ACK = 1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

endpackage

// File: rtl/ppm_debounce.sv
// rtl/ppm_debounce.sv - 2-FF synchronizer plus run-length debounce filter
//
// Ports:
//   CLK    system clock
//   RESET  synchronous, active-high reset
//   raw    asynchronous sensor level
//   filt   filtered level; flips after DB_LEN consecutive differing samples
module ppm_debounce
    import ppm_pkg::*;
#(
    parameter int DB_LEN = 8
) (
    input  logic CLK,
    input  logic RESET,
    input  logic raw,
    output logic filt
);

    localparam int CW = (DB_LEN > 1) ? $clog2(DB_LEN + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_LEN - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] run_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            run_cnt <= '0;
            filt    <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            // Any sample agreeing with the current level restarts the run,
            // so a glitch shorter than DB_LEN never reaches filt.
            if (sync_2 != filt) begin
                if (run_cnt == CNT_LAST) begin
                    filt    <= ~filt;
                    run_cnt <= '0;
                end else begin
                    run_cnt <= run_cnt + 1'b1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/pulse_period_meter.sv
// rtl/pulse_period_meter.sv - heartbeat interval meter feeding PERIOD/STATUS bytes
//
// Ports:
//   CLK     system clock
//   RESET   synchronous, active-high reset
//   PULSE   raw sensor pulse (asynchronous)
//   CTRL    bit0 EN, bit1 ACK (rising edge clears NEW/OVF), others ignored
//   PERIOD  last captured interval in ticks
//   STATUS  bit0 NEW, bit1 OVF, bits3:2 state, bit7 filtered level
//
// Build option: define PPM_AVG_EN to report the mean of the last four
// accepted intervals instead of the raw interval.
module pulse_period_meter
    import ppm_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int DB_LEN    = 8,
    parameter int MIN_TICKS = 40
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PULSE,
    input  logic [7:0] CTRL,
    output logic [7:0] PERIOD,
    output logic [7:0] STATUS
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [7:0]    MIN_IVL   = 8'(MIN_TICKS);

    logic          filt;
    logic          filt_d;
    logic          beat;
    logic          en_q;
    logic          ack_q;
    logic          ack_d;
    logic          ack_rise;
    logic [1:0]    state;
    logic [PW-1:0] presc;
    logic [7:0]    ivl;
    logic [7:0]    ivl_nxt;
    logic          tick;
    logic          meas;
    logic          accept;
    logic          timeout;
    logic          capture;
    logic          enter_arm;
    logic          new_flag;
    logic          ovf_flag;
    logic          unused_ctrl;

    assign unused_ctrl = ^CTRL[7:2];

    ppm_debounce #(
        .DB_LEN(DB_LEN)
    ) u_debounce (
        .CLK   (CLK),
        .RESET (RESET),
        .raw   (PULSE),
        .filt  (filt)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            filt_d <= 1'b0;
            beat   <= 1'b0;
            en_q   <= 1'b0;
            ack_q  <= 1'b0;
            ack_d  <= 1'b0;
        end else begin
            filt_d <= filt;
            beat   <= filt & ~filt_d;
            en_q   <= CTRL[CTRL_EN];
            ack_q  <= CTRL[CTRL_ACK];
            ack_d  <= ack_q;
        end
    end

    assign ack_rise = ack_q & ~ack_d;

    // The tick landing on the beat cycle is counted into the captured value,
    // so a spacing of exactly N*TICK_DIV cycles reads back as N.
    always_comb begin
        meas      = en_q && (state == ST_MEASURE);
        tick      = meas && (presc == PRESC_MAX);
        ivl_nxt   = tick ? sat_inc8(ivl) : ivl;
        accept    = meas && beat && (ivl_nxt >= MIN_IVL);
        timeout   = meas && tick && (ivl_nxt == 8'hFF) && !accept;
        capture   = accept || timeout;
        enter_arm = en_q && ((state == ST_IDLE) || timeout);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
            presc <= '0;
            ivl   <= 8'd0;
        end else if (!en_q) begin
            state <= ST_IDLE;
            presc <= '0;
            ivl   <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    presc <= '0;
                    ivl   <= 8'd0;
                    state <= ST_ARM;
                end
                ST_ARM: begin
                    presc <= '0;
                    ivl   <= 8'd0;
                    if (beat) begin
                        state <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (accept) begin
                        presc <= '0;
                        ivl   <= 8'd0;
                    end else if (timeout) begin
                        presc <= '0;
                        ivl   <= 8'd0;
                        state <= ST_ARM;
                    end else begin
                        // Beats inside the refractory window fall through here
                        // and leave the running interval untouched.
                        presc <= tick ? '0 : presc + 1'b1;
                        ivl   <= ivl_nxt;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    presc <= '0;
                    ivl   <= 8'd0;
                end
            endcase
        end
    end

    // A capture or timeout outranks an acknowledge arriving in the same cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            new_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            if (capture) begin
                new_flag <= 1'b1;
            end else if (ack_rise) begin
                new_flag <= 1'b0;
            end
            if (timeout) begin
                ovf_flag <= 1'b1;
            end else if (ack_rise) begin
                ovf_flag <= 1'b0;
            end
        end
    end

`ifdef PPM_AVG_EN
    logic [7:0] hist [4];
    logic       first;
    logic [7:0] h0_src;
    logic [7:0] h1_src;
    logic [7:0] h2_src;
    logic [9:0] avg_sum;

    // The first capture of a new arming seeds every slot, so the mean starts
    // at that interval instead of being dragged down by stale history.
    always_comb begin
        h0_src  = first ? ivl_nxt : hist[0];
        h1_src  = first ? ivl_nxt : hist[1];
        h2_src  = first ? ivl_nxt : hist[2];
        avg_sum = {2'b00, ivl_nxt} + {2'b00, h0_src} + {2'b00, h1_src} + {2'b00, h2_src};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            PERIOD  <= 8'd0;
            first   <= 1'b1;
            hist[0] <= 8'd0;
            hist[1] <= 8'd0;
            hist[2] <= 8'd0;
            hist[3] <= 8'd0;
        end else begin
            if (accept) begin
                hist[0] <= ivl_nxt;
                hist[1] <= h0_src;
                hist[2] <= h1_src;
                hist[3] <= h2_src;
                PERIOD  <= avg_sum[9:2];
                first   <= 1'b0;
            end else if (timeout) begin
                PERIOD <= 8'hFF;
            end
            if (enter_arm) begin
                first <= 1'b1;
            end
        end
    end
`else
    logic unused_arm;

    assign unused_arm = enter_arm;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            PERIOD <= 8'd0;
        end else if (capture) begin
            PERIOD <= accept ? ivl_nxt : 8'hFF;
        end
    end
`endif

    always_comb begin
        STATUS                            = 8'h00;
        STATUS[STS_NEW]                   = new_flag;
        STATUS[STS_OVF]                   = ovf_flag;
        STATUS[STS_STATE_HI:STS_STATE_LO] = state;
        STATUS[STS_LVL]                   = filt;
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// tb/tb_pulse_period_meter.sv - directed self-checking bench for pulse_period_meter
module tb_pulse_period_meter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       PULSE;
    logic [7:0] CTRL;
    logic [7:0] PERIOD;
    logic [7:0] STATUS;

    int checks   = 0;
    int failures = 0;

`ifdef PPM_AVG_EN
    localparam logic [7:0] EXP_P4 = 8'd11;
`else
    localparam logic [7:0] EXP_P4 = 8'd14;
`endif

    always #5 CLK = ~CLK;

    pulse_period_meter #(
        .TICK_DIV  (4),
        .DB_LEN    (3),
        .MIN_TICKS (5)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .PULSE  (PULSE),
        .CTRL   (CTRL),
        .PERIOD (PERIOD),
        .STATUS (STATUS)
    );

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, act, exp);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Six-cycle pulse; returns just after the edge where PERIOD/STATUS update.
    // with_ack raises ACK so its rising edge is seen on that same update edge.
    task automatic pulse6(input bit with_ack);
        PULSE = 1'b1;
        gap(5);
        if (with_ack) CTRL[1] = 1'b1;
        gap(1);
        PULSE = 1'b0;
        gap(1);
        CTRL[1] = 1'b0;
    endtask

    task automatic ack_pulse();
        CTRL[1] = 1'b1;
        gap(1);
        CTRL[1] = 1'b0;
        gap(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic lvl_seen;
        RESET = 1'b1;
        PULSE = 1'b1;
        CTRL  = 8'h00;
        gap(1);
        PULSE = 1'b0;
        gap(1);
        RESET = 1'b0;
        PULSE = 1'b0;
        chk("rst_period", PERIOD, 8'h00);
        chk("rst_status", STATUS, 8'h00);
        gap(3);
        chk("idle_status", STATUS, 8'h00);

        CTRL = 8'h01;
        gap(1);
        chk("en_latency", STATUS, 8'h00);
        gap(1);
        chk("arm_status", STATUS, 8'h04);

        pulse6(1'b0);
        chk("a_status", STATUS & 8'h7F, 8'h08);
        chk("a_period", PERIOD, 8'h00);
        gap(33);
        pulse6(1'b0);
        chk("b_period", PERIOD, 8'd10);
        chk("b_status", STATUS & 8'h7F, 8'h09);
        chk("b_level", {7'b0, STATUS[7]}, 8'h01);
        gap(8);
        chk("b_status_settled", STATUS, 8'h09);

        gap(5);
        lvl_seen = 1'b0;
        PULSE = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (i == 1) PULSE = 1'b0;
            lvl_seen = lvl_seen | STATUS[7];
        end
        chk("glitch_level", {7'b0, lvl_seen}, 8'h00);
        gap(8);
        pulse6(1'b0);
        chk("c_period", PERIOD, 8'd10);

        ack_pulse();
        chk("ack_clear", STATUS & 8'h7F, 8'h08);
        gap(3);
        pulse6(1'b0);
        chk("extra_status", STATUS & 8'h7F, 8'h08);
        chk("extra_period", PERIOD, 8'd10);
        gap(21);
        pulse6(1'b0);
        chk("d_period", PERIOD, 8'd10);
        chk("d_status", STATUS & 8'h7F, 8'h09);

        gap(1019);
        chk("pre_timeout_status", STATUS, 8'h09);
        chk("pre_timeout_period", PERIOD, 8'd10);
        gap(1);
        chk("timeout_period", PERIOD, 8'hFF);
        chk("timeout_status", STATUS, 8'h07);
        ack_pulse();
        chk("timeout_ack", STATUS, 8'h04);
        pulse6(1'b0);
        chk("rearm_status", STATUS & 8'h7F, 8'h08);
        chk("rearm_period", PERIOD, 8'hFF);

        gap(33);
        pulse6(1'b1);
        chk("ack_vs_capture", STATUS & 8'h7F, 8'h09);
        chk("f_period", PERIOD, 8'd10);
        gap(3);
        chk("new_held", STATUS & 8'h7F, 8'h09);

        CTRL = 8'h00;
        gap(2);
        chk("disable_status", STATUS & 8'h7F, 8'h01);
        chk("disable_period", PERIOD, 8'd10);

        CTRL = 8'h01;
        gap(2);
        chk("reenable_state", STATUS & 8'h0C, 8'h04);
        pulse6(1'b0);
        gap(33);
        pulse6(1'b0);
        chk("avg_p1", PERIOD, 8'd10);
        gap(33);
        pulse6(1'b0);
        chk("avg_p2", PERIOD, 8'd10);
        gap(33);
        pulse6(1'b0);
        chk("avg_p3", PERIOD, 8'd10);
        gap(49);
        pulse6(1'b0);
        chk("avg_p4", PERIOD, EXP_P4);
        gap(1025);
        chk("avg_timeout", PERIOD, 8'hFF);
        pulse6(1'b0);
        gap(73);
        pulse6(1'b0);
        chk("avg_after_rearm", PERIOD, 8'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_period_meter.md
# pulse_period_meter

Front-end measurement stage for the heart-rate monitor. Conditions the raw heartbeat sensor pulse, measures the beat-to-beat interval in prescaled ticks, and presents the result as two bytes on the data RAM's input ports: PERIOD on IOA, STATUS on IOB. Software control arrives from the RAM's output port IOD as CTRL. The processor reads these bytes and converts the interval to BPM through the BCD lookup table in data memory.

## Interface
- TICK_DIV, 50000: CLK cycles per measurement tick.
- DB_LEN, 8: consecutive identical CLK samples needed to change the filtered level.
- MIN_TICKS, 40: refractory window; beats arriving with the interval count below this are ignored.

- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- PULSE  in  1  raw sensor pulse, asynchronous, active-high
- CTRL  in  8  from IOD. bit0 EN (measure enable); bit1 ACK (rising edge clears flags); other bits ignored.
- PERIOD  out  8  last captured interval in ticks; drives IOA
- STATUS  out  8  drives IOB. bit0 NEW; bit1 OVF; bits3:2 state code; bit7 filtered beat level; other bits 0.

## Operation
- Synchronizer: 2-FF chain on PULSE, giving sync.
- Debounce: counter tracks sync != filt. filt flips on the DB_LEN-th consecutive such cycle. The counter clears whenever sync == filt.
- Beat: registered rising edge of filt, a 1-cycle pulse.
- Prescaler: counts 0..TICK_DIV-1 and emits tick on wrap. It clears on every accepted beat and whenever the state is not MEASURE.
- IVL: 8-bit tick counter, increments on tick and saturates at 255.
- State machine (encoding IDLE=0, ARM=1, MEASURE=2):
  - IDLE: counters held at 0. Go to ARM when EN=1.
  - ARM: wait for a beat. On beat: IVL=0, go to MEASURE. No capture.
  - MEASURE, beat with IVL < MIN_TICKS: ignored, counting continues.
  - MEASURE, beat with IVL >= MIN_TICKS: PERIOD=IVL, NEW=1, IVL=0.
  - MEASURE, IVL reaches 255 (timeout): PERIOD=255, NEW=1, OVF=1, go to ARM.
  - Any state with EN=0: go to IDLE next cycle. PERIOD, NEW and OVF hold.
- ACK: a rising edge of CTRL[1] (registered against its previous value) clears NEW and OVF.
  - If ACK coincides with a capture or timeout, the set wins.
- Timeout and beat in the same cycle: the beat capture wins, no OVF.
- Reset values: PERIOD=0, STATUS=0, state IDLE, all counters 0, filt=0.
- RESET mid-measurement discards the partial interval; no capture occurs.

## Timing
- PULSE sampled high at edge 1 → sync high after edge 2.
- filt rises at edge DB_LEN+2.
- beat asserted after edge DB_LEN+3.
- PERIOD and STATUS update at edge DB_LEN+4, registered outputs with no combinational path from inputs.
- CTRL EN takes effect one cycle after sampling. ACK clears flags at the edge after its rising edge is detected, 2 edges total.
- Interval resolution is 1 tick. Measured value is floor(beat spacing in cycles / TICK_DIV), ±1 tick.

## Configuration
- PPM_AVG_EN defined: PERIOD reports the mean of the last 4 accepted intervals.
  - 10-bit sum >> 2, truncated.
  - The first capture after entering ARM loads all 4 history slots with that interval.
  - Timeout captures (255) bypass the history and are output raw.
- PPM_AVG_EN undefined: PERIOD reports the raw interval. No history registers are built.
- NEW and OVF behave identically in both builds.

## Structure
- ppm_pkg contains:
  - state enum (IDLE, ARM, MEASURE);
  - STATUS bit indices (NEW=0, OVF=1, STATE=3:2, LVL=7);
  - CTRL bit indices (EN=0, ACK=1).
- Sub-module ppm_debounce (synchronizer + debounce filter, parameter DB_LEN) outputs filt.
- Prescaler, edge detect, FSM, capture and averaging live in the top module.

## Test plan
Bench parameters: TICK_DIV=4, DB_LEN=3, MIN_TICKS=5.
- Reset held 2 cycles with PULSE toggling → PERIOD=0x00, STATUS=0x00.
- EN=1; 6-cycle-wide pulses every 40 CLK. After the second pulse, PERIOD=10 and STATUS=0x09 (NEW, MEASURE), at edge DB_LEN+4 after the pulse.
- 2-cycle glitch between valid pulses → no beat. PERIOD stays 10; bit7 never rises.
- Extra pulse 12 CLK after a valid beat → ignored. Next pulse 40 CLK after the valid beat → PERIOD=10.
- No pulse for 1020+ CLK → PERIOD=255, STATUS=0x07 (NEW, OVF, ARM). The next pulse produces no capture. ACK pulse → STATUS=0x04. ACK in the same cycle as a capture → NEW remains 1.
- PPM_AVG_EN build: intervals 10, 10, 10, 14 ticks → PERIOD sequence 10, 10, 10, 11. After a timeout, re-arm, then interval 20 → PERIOD=20.
